// File: rtl/matrix_alu_pkg.sv
// Shared types for the matrix ALU: opcode and FSM state encodings, plus the
// row-major element index helper used to locate element (r,c) in a matrix word.
package matrix_alu_pkg;

  typedef enum logic [2:0] {
    OpAdd       = 3'd0,
    OpSub       = 3'd1,
    OpMul       = 3'd2,
    OpTranspose = 3'd3,
    OpScale     = 3'd4
  } opcode_e;

  // Opcodes above this value are rejected with an Error pulse.
  localparam logic [2:0] OpLastLegal = 3'd4;

  typedef enum logic [2:0] {
    StIdle,
    StRdA,
    StWaitA,
    StRdB,
    StWaitB,
    StExec,
    StWr,
    StDone
  } state_e;

  // Row-major element index; element (r,c) lives at bits [idx*EW +: EW].
  function automatic int unsigned elem_idx(input int unsigned r, input int unsigned c,
                                           input int unsigned n);
    return r * n + c;
  endfunction

endpackage

// File: rtl/matrix_alu_param_if.sv
// Command and memory bus bundle for matrix_alu_param.
// master: the execution unit / memory side (drives commands and read data).
// slave : the matrix ALU (drives status, bus address, strobes and write data).
// Signals: start/opcode/src_a/src_b/dst/scalar (command), busy/done/error (status),
//          mem_addr/n_read/n_write/mem_data_in/mem_data_out (shared memory bus).
interface matrix_alu_param_if #(
  parameter int unsigned N  = 4,
  parameter int unsigned EW = 16,
  parameter int unsigned AW = 16,
  parameter int unsigned DW = N * N * EW
);
  logic          start;
  logic [2:0]    opcode;
  logic [AW-1:0] src_a;
  logic [AW-1:0] src_b;
  logic [AW-1:0] dst;
  logic [EW-1:0] scalar;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW-1:0] mem_addr;
  logic          n_read;
  logic          n_write;
  logic [DW-1:0] mem_data_in;
  logic [DW-1:0] mem_data_out;

  modport master (
    output start, opcode, src_a, src_b, dst, scalar, mem_data_in,
    input  busy, done, error, mem_addr, n_read, n_write, mem_data_out
  );

  modport slave (
    input  start, opcode, src_a, src_b, dst, scalar, mem_data_in,
    output busy, done, error, mem_addr, n_read, n_write, mem_data_out
  );
endinterface

// File: rtl/matrix_dot_product.sv
// Combinational N-term dot product of EW-bit elements, truncated to EW bits.
// Ports: i_a, i_b - N packed elements each (element k at [k*EW +: EW]);
//        o_sum    - sum of i_a[k]*i_b[k] modulo 2^EW.
module matrix_dot_product #(
  parameter int unsigned N  = 4,
  parameter int unsigned EW = 16
) (
  input  logic [N*EW-1:0] i_a,
  input  logic [N*EW-1:0] i_b,
  output logic [EW-1:0]   o_sum
);

  logic [EW-1:0] w_acc;

  always_comb begin
    w_acc = '0;
    for (int k = 0; k < N; k++) begin
      w_acc = w_acc + i_a[k*EW +: EW] * i_b[k*EW +: EW];
    end
  end

  assign o_sum = w_acc;

endmodule

// File: rtl/matrix_alu_param.sv
// Matrix ALU: one add/sub/mul/transpose/scale per command on N x N EW-bit
// matrices, one matrix per memory word. Operands are fetched over the shared
// bus, the result is written back to Dst, then Done pulses for one cycle.
// Ports: i_clk - rising-edge clock; i_rst - synchronous active-high reset;
//        io_bus - command/status and memory bus (slave side).
module matrix_alu_param
  import matrix_alu_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned EW = 16,
  parameter int unsigned AW = 16,
  parameter int unsigned DW = N * N * EW
) (
  input  logic                i_clk,
  input  logic                i_rst,
  matrix_alu_param_if.slave   io_bus
);

  localparam int unsigned RW = (N > 1) ? $clog2(N) : 1;

  state_e        r_state, w_state_d;
  opcode_e       r_op;
  logic [AW-1:0] r_src_a, r_src_b, r_dst;
  logic [EW-1:0] r_scalar;
  logic [DW-1:0] r_a, r_b, r_res;
  logic [RW-1:0] r_row, r_col;
  logic          r_error;

  logic          w_op_legal;
  logic          w_mul_last;
  logic [DW-1:0] w_ew_res;
  logic [N*EW-1:0] w_a_row, w_b_col;
  logic [EW-1:0] w_dot;

  assign w_op_legal = (io_bus.opcode <= OpLastLegal);
  assign w_mul_last = (r_row == RW'(N - 1)) && (r_col == RW'(N - 1));

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:  if (io_bus.start && w_op_legal) w_state_d = StRdA;
      StRdA:   w_state_d = StWaitA;
      StWaitA: w_state_d = (r_op inside {OpAdd, OpSub, OpMul}) ? StRdB : StExec;
      StRdB:   w_state_d = StWaitB;
      StWaitB: w_state_d = StExec;
      StExec:  if (r_op != OpMul || w_mul_last) w_state_d = StWr;
      StWr:    w_state_d = StDone;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= StIdle;
    else       r_state <= w_state_d;
  end

  // Bus and status outputs are decoded from state, so reset forces them idle.
  always_comb begin
    io_bus.busy         = (r_state != StIdle) && (r_state != StDone);
    io_bus.done         = (r_state == StDone);
    io_bus.error        = r_error;
    io_bus.n_read       = 1'b1;
    io_bus.n_write      = 1'b1;
    io_bus.mem_addr     = '0;
    io_bus.mem_data_out = '0;
    case (r_state)
      StRdA: begin
        io_bus.n_read   = 1'b0;
        io_bus.mem_addr = r_src_a;
      end
      StRdB: begin
        io_bus.n_read   = 1'b0;
        io_bus.mem_addr = r_src_b;
      end
      StWr: begin
        io_bus.n_write      = 1'b0;
        io_bus.mem_addr     = r_dst;
        io_bus.mem_data_out = r_res;
      end
      default: ;
    endcase
  end

  // Single-cycle element-wise result for everything except MUL.
  always_comb begin
    w_ew_res = '0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        case (r_op)
          OpAdd: w_ew_res[elem_idx(r, c, N)*EW +: EW] =
              r_a[elem_idx(r, c, N)*EW +: EW] + r_b[elem_idx(r, c, N)*EW +: EW];
          OpSub: w_ew_res[elem_idx(r, c, N)*EW +: EW] =
              r_a[elem_idx(r, c, N)*EW +: EW] - r_b[elem_idx(r, c, N)*EW +: EW];
          OpTranspose: w_ew_res[elem_idx(r, c, N)*EW +: EW] =
              r_a[elem_idx(c, r, N)*EW +: EW];
          OpScale: w_ew_res[elem_idx(r, c, N)*EW +: EW] =
              r_a[elem_idx(r, c, N)*EW +: EW] * r_scalar;
          default: ;
        endcase
      end
    end
  end

  // MUL operands: current row of A and current column of B.
  always_comb begin
    w_a_row = '0;
    w_b_col = '0;
    for (int r = 0; r < N; r++) begin
      if (r_row == RW'(r)) begin
        for (int k = 0; k < N; k++) begin
          w_a_row[k*EW +: EW] = r_a[elem_idx(r, k, N)*EW +: EW];
        end
      end
    end
    for (int c = 0; c < N; c++) begin
      if (r_col == RW'(c)) begin
        for (int k = 0; k < N; k++) begin
          w_b_col[k*EW +: EW] = r_b[elem_idx(k, c, N)*EW +: EW];
        end
      end
    end
  end

  matrix_dot_product #(
    .N  (N),
    .EW (EW)
  ) u_dot (
    .i_a   (w_a_row),
    .i_b   (w_b_col),
    .o_sum (w_dot)
  );

  // Datapath registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_op     <= OpAdd;
      r_src_a  <= '0;
      r_src_b  <= '0;
      r_dst    <= '0;
      r_scalar <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_row    <= '0;
      r_col    <= '0;
      r_error  <= 1'b0;
    end else begin
      r_error <= 1'b0;
      case (r_state)
        StIdle: begin
          r_row <= '0;
          r_col <= '0;
          if (io_bus.start) begin
            r_src_a  <= io_bus.src_a;
            r_src_b  <= io_bus.src_b;
            r_dst    <= io_bus.dst;
            r_scalar <= io_bus.scalar;
            if (w_op_legal) r_op <= opcode_e'(io_bus.opcode);
            else            r_error <= 1'b1;
          end
        end
        // Read data arrives the cycle after the strobe.
        StWaitA: r_a <= io_bus.mem_data_in;
        StWaitB: r_b <= io_bus.mem_data_in;
        StExec: begin
          if (r_op == OpMul) begin
            for (int r = 0; r < N; r++) begin
              for (int c = 0; c < N; c++) begin
                if (r_row == RW'(r) && r_col == RW'(c)) begin
                  r_res[elem_idx(r, c, N)*EW +: EW] <= w_dot;
                end
              end
            end
            if (r_col == RW'(N - 1)) begin
              r_col <= '0;
              r_row <= r_row + 1'b1;
            end else begin
              r_col <= r_col + 1'b1;
            end
          end else begin
            r_res <= w_ew_res;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/matrix_alu_param.md
# matrix_alu_param

Parametrised successor to the fixed 4x4 matrix adder. Executes one matrix operation per command: add, subtract, multiply, transpose or scalar-scale, on square N x N matrices of EW-bit elements. Fetches operands from main memory and writes the result back over the shared read/write bus. Sits beside the execution unit, which issues commands and waits for Done.

## Interface
- N, default 4: matrix dimension (2..8)
- EW, default 16: element width in bits
- AW, default 16: memory address width
- DW, default N*N*EW: memory word width, one matrix per word (256 at defaults)

- Clk  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- Start  in  1  command strobe, sampled only in IDLE
- Opcode  in  3  0 ADD, 1 SUB, 2 MUL, 3 TRANSPOSE, 4 SCALE, 5-7 illegal
- SrcA  in  AW  address of operand A
- SrcB  in  AW  address of operand B (ignored for TRANSPOSE/SCALE)
- Dst  in  AW  result address
- Scalar  in  EW  multiplier for SCALE
- Busy  out  1  high from the cycle after Start acceptance until Done
- Done  out  1  one-cycle completion pulse
- Error  out  1  one-cycle pulse on illegal opcode
- MemAddr  out  AW  bus address
- nRead  out  1  active-low read strobe, one cycle per read
- nWrite  out  1  active-low write strobe, one cycle per write
- MemDataIn  in  DW  read data, valid the cycle after nRead low
- MemDataOut  out  DW  write data, valid while nWrite low

## Operation
- Element (r,c) is at bits [(r*N+c)*EW +: EW]; row-major, element (0,0) at LSBs.
- States: IDLE, RD_A, WAIT_A, RD_B, WAIT_B, EXEC, WR, DONE.
- IDLE: on Start, latch Opcode/SrcA/SrcB/Dst/Scalar.
  - Legal opcode: go to RD_A.
  - Illegal opcode: pulse Error next cycle, stay IDLE, no bus activity.
- RD_A: MemAddr=SrcA, nRead=0. WAIT_A: capture MemDataIn into A register.
- After WAIT_A: ADD/SUB/MUL go to RD_B/WAIT_B (same pattern with SrcB into B). TRANSPOSE/SCALE go straight to EXEC.
- EXEC:
  - ADD/SUB/TRANSPOSE/SCALE: all elements in one cycle.
  - MUL: one result element per cycle, row-major index 0..N*N-1, each an N-term dot product; N*N cycles.
- WR: MemAddr=Dst, MemDataOut=result, nWrite=0. DONE: Done=1, Busy=0, return to IDLE.
- Arithmetic: all results are modulo 2^EW (unsigned wrap, no saturation, no overflow flag). Products and dot-product sums are truncated to EW bits.
- Dst may equal SrcA or SrcB; operands are latched before the write, so the result is correct.
- Start while Busy is ignored (not queued).
- Reset in any state:
  - Next cycle in IDLE.
  - nRead=nWrite=1; Busy=Done=Error=0.
  - MemAddr=0, MemDataOut=0; MUL index cleared.
  - A write in progress is not issued.

## Timing
- Reset values: Busy 0, Done 0, Error 0, nRead 1, nWrite 1, MemAddr 0, MemDataOut 0.
- Start sampled at edge 0. nRead low in cycle 1. Fixed read latency is 1 cycle.
- Done pulse cycle after Start: ADD/SUB 7, MUL 6+N*N (22 at N=4), TRANSPOSE/SCALE 5.
- Error pulse in cycle 1 after an illegal Start.
- nRead and nWrite are never low simultaneously; each is low for exactly one cycle per access.
- Next Start is accepted in the cycle Done is high (state IDLE at that edge).

## Structure
- Package matrix_alu_pkg: opcode enum, state enum, element-index helper function. N and EW stay module parameters.
- One sub-module, matrix_dot_product: combinational N-term EW-bit multiply-accumulate, used by MUL.
- Control FSM and the element-wise datapath live in matrix_alu_param.

## Test plan
- ADD, N=4, EW=16: A elements = index k (0..15), B all 0xFFFF, Dst=5 -> mem[5] element k = k-1 mod 2^16 (element 0 = 0xFFFF); Done in cycle 7.
- MUL: A = identity, B elements = k -> result equals B. Then A all 2, B all 3 -> every element 24; Done in cycle 22.
- TRANSPOSE: A element (r,c) = 16r+c -> result (r,c) = 16c+r; only one nRead pulse; Done in cycle 5.
- SCALE with Scalar=0x8000, A element = 3 -> every element 0x8000 (wrap).
- Opcode 6 -> Error pulse in cycle 1; nRead/nWrite stay high; Busy stays 0.
- Reset asserted during MUL EXEC -> Busy=0 next cycle, no nWrite pulse. A following ADD with Dst=SrcA completes correctly.
